x_timer_ctrl: RTL and testbench

- Sequencing controller around a 16-bit up-counter: start/stop control, a programmable terminal count and an 8-bit prescaler.
- Supports one-shot and periodic modes.
- Emits a single-cycle terminal pulse and a sticky done flag.
- Sits between a host/sequencer FSM and any logic that needs a timed event or a free-running count.

---
 rtl/x_timer_ctrl.sv | 106 ++++++++++
 tb/tb_x_timer_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/x_timer_ctrl.sv
// x_timer_ctrl
//   Start/stop sequencing around a 16-bit up-counter with an 8-bit prescaler.
//   It supports one-shot and periodic modes. A terminal count produces a
//   one-cycle tick. A one-shot run then parks in DONE with the count held.
//
// Ports
//   i_clk       clock, all state on rising edge
//   i_rst       synchronous reset, active-high
//   i_start     pulse: latch period/prescale/mode, clear count, enter RUN
//   i_stop      pulse: abort to IDLE (wins over i_start)
//   i_periodic  mode, sampled with i_start (1 = periodic, 0 = one-shot)
//   i_period    terminal count N, sampled with i_start
//   i_prescale  prescale P, sampled with i_start (step every P+1 cycles)
//   o_count     current count
//   o_busy      high while in RUN
//   o_tick      one-cycle pulse after each terminal step
//   o_done      high while in DONE
module x_timer_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_periodic,
  input  logic [15:0] i_period,
  input  logic [7:0]  i_prescale,
  output logic [15:0] o_count,
  output logic        o_busy,
  output logic        o_tick,
  output logic        o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] count;
  logic [7:0]  pre;
  logic [15:0] n_lat;
  logic [7:0]  p_lat;
  logic        per_lat;
  logic        tick_q;
  logic        busy_q;
  logic        done_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      pre     <= '0;
      n_lat   <= '0;
      p_lat   <= '0;
      per_lat <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // The tick is a pulse: only a terminal step below raises it.
      tick_q <= 1'b0;
      if (i_stop) begin
        state  <= ST_IDLE;
        count  <= '0;
        pre    <= '0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else if (i_start) begin
        // A start in RUN is a restart. Any progress is discarded.
        n_lat   <= i_period;
        p_lat   <= i_prescale;
        per_lat <= i_periodic;
        count   <= '0;
        pre     <= '0;
        state   <= ST_RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (state == ST_RUN) begin
        if (pre == p_lat) begin
          pre <= '0;
          if (count == n_lat) begin
            tick_q <= 1'b1;
            if (per_lat) begin
              count <= '0;
            end else begin
              // One-shot: the count holds N while the timer sits in DONE.
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            count <= count + 16'd1;
          end
        end else begin
          pre <= pre + 8'd1;
        end
      end
    end
  end

  assign o_count = count;
  assign o_busy  = busy_q;
  assign o_tick  = tick_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_x_timer_ctrl.sv
module tb_x_timer_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_stop;
  logic        i_periodic;
  logic [15:0] i_period;
  logic [7:0]  i_prescale;
  logic [15:0] o_count;
  logic        o_busy;
  logic        o_tick;
  logic        o_done;

  x_timer_ctrl dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_periodic (i_periodic),
    .i_period   (i_period),
    .i_prescale (i_prescale),
    .o_count    (o_count),
    .o_busy     (o_busy),
    .o_tick     (o_tick),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] count;
    logic        busy;
    logic        tick;
    logic        done;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference state: whether a run is active, and the cycle index since its start edge.
  bit m_act = 1'b0;
  int m_c   = 0;
  int m_n   = 0;
  int m_p   = 0;
  bit m_per = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Closed-form expectation for cycle c (c=1 is the first cycle after the start edge).
  // Cycle c corresponds to elapsed count e=c-1. Each step lasts P+1 cycles,
  // and one full period is (N+1)(P+1) cycles.
  function automatic exp_t model_out(input int c, input int n, input int p, input bit per);
    exp_t r;
    int   e;
    int   s;
    int   len;
    e   = c - 1;
    s   = p + 1;
    len = (n + 1) * s;
    r   = '0;
    if (per) begin
      r.count = 16'((e % len) / s);
      r.busy  = 1'b1;
      r.tick  = (e > 0) && ((e % len) == 0);
    end else if (e < len) begin
      r.count = 16'(e / s);
      r.busy  = 1'b1;
    end else begin
      r.count = 16'(n);
      r.done  = 1'b1;
      r.tick  = (e == len);
    end
    return r;
  endfunction

  // Called at a falling edge: drive this cycle's inputs, push the expectation
  // for the next cycle, then check it one falling edge later.
  task automatic cyc(input bit rst, input bit start, input bit stop, input bit per,
                     input logic [15:0] n, input logic [7:0] p);
    exp_t e;
    i_rst      = rst;
    i_start    = start;
    i_stop     = stop;
    i_periodic = per;
    i_period   = n;
    i_prescale = p;
    if (rst || stop) begin
      m_act = 1'b0;
    end else if (start) begin
      m_act = 1'b1;
      m_c   = 1;
      m_n   = int'(n);
      m_p   = int'(p);
      m_per = per;
    end else if (m_act) begin
      m_c++;
    end
    e = m_act ? model_out(m_c, m_n, m_p, m_per) : '0;
    sb_q.push_back(e);
    @(negedge i_clk);
    e = sb_q.pop_front();
    chk_val("count", 32'(o_count), 32'(e.count));
    chk_val("busy",  32'(o_busy),  32'(e.busy));
    chk_val("tick",  32'(o_tick),  32'(e.tick));
    chk_val("done",  32'(o_done),  32'(e.done));
  endtask

  // Idle cycles with config inputs scrambled: they must be ignored without a start.
  task automatic run(input int k);
    logic [15:0] jn;
    logic [7:0]  jp;
    bit          jm;
    for (int i = 0; i < k; i++) begin
      jn = 16'($urandom);
      jp = 8'($urandom);
      jm = 1'($urandom);
      cyc(1'b0, 1'b0, 1'b0, jm, jn, jp);
    end
  endtask

  initial begin
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_stop     = 1'b0;
    i_periodic = 1'b0;
    i_period   = '0;
    i_prescale = '0;
    @(negedge i_clk);
    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'd9, 8'd3);
    run(2);

    // One-shot N=3 P=0
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 8'd0);
    run(8);

    // Periodic N=2 P=1 from DONE: ticks in cycles 7, 13, 19
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 8'd1);
    run(20);

    // Stop in cycle 3 of periodic N=5 P=0
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 8'd0);
    run(2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'd5, 8'd0);
    run(8);

    // Start and stop together while running: stop wins, nothing latched
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'd7, 8'd0);
    run(3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 8'd0);
    run(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 8'd0);
    run(6);

    // Restart: N=4 then start again in cycle 3 with N=1
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 8'd0);
    run(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 8'd0);
    run(8);

    // N=0 boundaries: periodic with P=3, then one-shot with P=0
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 8'd3);
    run(12);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0);
    run(4);

    // Large prescale, one-shot
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 8'd255);
    run(780);

    // Reset mid-run, asserted in cycle 2
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'd10, 8'd0);
    run(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 8'd0);
    run(3);

    // Periodic N=FFFF P=0: first tick and count wrap in cycle 65537
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 8'd0);
    run(65540);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
